// File: rtl/pet_pkg.sv
// Shared definitions for the pet action path: action codes, action count and arbiter FSM states.
// The stats core decodes the same ACT_* codes.
package pet_pkg;

  localparam int unsigned NUM_ACT = 4;

  localparam logic [1:0] ACT_FEED  = 2'd0;
  localparam logic [1:0] ACT_SLEEP = 2'd1;
  localparam logic [1:0] ACT_PLAY  = 2'd2;
  localparam logic [1:0] ACT_HEAL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first eligible index at or after the pointer,
// wrapping 3 -> 0.
module rr_pick4
  import pet_pkg::*;
(
  input  logic [NUM_ACT-1:0] eligible,
  input  logic [1:0]         pointer,
  output logic               grant_valid,
  output logic [1:0]         grant_code
);

  always_comb begin
    grant_valid = 1'b0;
    grant_code  = pointer;
    for (int i = 0; i < NUM_ACT; i++) begin
      if (!grant_valid && eligible[pointer + 2'(i)]) begin
        grant_valid = 1'b1;
        grant_code  = pointer + 2'(i);
      end
    end
  end

endmodule

// File: rtl/pet_action_arbiter.sv
// Latches pet action requests, arbitrates them round-robin and issues one at a time over
// valid/ready, with a per-action cooldown in seconds. PET_HEAL_PRIORITY_EN: HEAL always wins.
module pet_action_arbiter
  import pet_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50,
  parameter int unsigned COOLDOWN_S = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_feed,
  input  logic               req_sleep,
  input  logic               req_play,
  input  logic               req_heal,
  input  logic               dead,
  input  logic               test_mode,
  output logic               act_valid,
  output logic [1:0]         act_code,
  input  logic               act_ready,
  output logic [NUM_ACT-1:0] cooldown,
  output logic [NUM_ACT-1:0] pending,
  output logic               sec_tick
);

  localparam int unsigned     TickW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(CLK_FREQ - 1);
  localparam logic [3:0]      CdLoad  = 4'(COOLDOWN_S);

  logic [TickW-1:0]   tick_cnt_q;
  logic               sec_tick_q;
  logic [NUM_ACT-1:0] req_q;
  logic [NUM_ACT-1:0] pending_q, pending_d;
  logic [3:0]         cd_cnt_q [NUM_ACT];
  logic [3:0]         cd_cnt_d [NUM_ACT];
  arb_state_e         state_q;
  logic               act_valid_q;
  logic [1:0]         act_code_q;
  logic [1:0]         ptr_q;

  logic [NUM_ACT-1:0] req_now;
  logic [NUM_ACT-1:0] req_rise;
  logic [NUM_ACT-1:0] cd_flag;
  logic [NUM_ACT-1:0] eligible;
  logic               accept;
  logic [NUM_ACT-1:0] accept_mask;
  logic               rr_valid;
  logic [1:0]         rr_code;
  logic               pick_valid;
  logic [1:0]         pick_code;

  // Free-running one-second tick, independent of dead/test_mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      sec_tick_q <= 1'b0;
    end else if (tick_cnt_q == TickMax) begin
      tick_cnt_q <= '0;
      sec_tick_q <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
      sec_tick_q <= 1'b0;
    end
  end

  assign req_now  = {req_heal, req_play, req_sleep, req_feed};
  assign req_rise = req_now & ~req_q;

  always_comb begin
    for (int i = 0; i < NUM_ACT; i++) begin
      cd_flag[i] = (cd_cnt_q[i] != 4'd0);
    end
  end

  assign eligible    = pending_q & ~cd_flag;
  assign accept      = (state_q == WAIT_ACK) && act_valid_q && act_ready && !dead;
  assign accept_mask = accept ? (4'b0001 << act_code_q) : 4'b0000;

  // Edges are dropped while the action is already pending or cooling down.
  always_comb begin
    if (dead) begin
      pending_d = '0;
    end else begin
      pending_d = (pending_q & ~accept_mask) | (req_rise & ~pending_q & ~cd_flag);
    end
  end

  // A load wins over a same-cycle decrement.
  always_comb begin
    for (int i = 0; i < NUM_ACT; i++) begin
      if (accept_mask[i]) begin
        cd_cnt_d[i] = CdLoad;
      end else if (sec_tick_q && cd_flag[i]) begin
        cd_cnt_d[i] = cd_cnt_q[i] - 4'd1;
      end else begin
        cd_cnt_d[i] = cd_cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q     <= '0;
      pending_q <= '0;
      for (int i = 0; i < NUM_ACT; i++) begin
        cd_cnt_q[i] <= 4'd0;
      end
    end else begin
      req_q     <= req_now;
      pending_q <= pending_d;
      for (int i = 0; i < NUM_ACT; i++) begin
        cd_cnt_q[i] <= cd_cnt_d[i];
      end
    end
  end

  rr_pick4 u_pick (
    .eligible    (eligible),
    .pointer     (ptr_q),
    .grant_valid (rr_valid),
    .grant_code  (rr_code)
  );

`ifdef PET_HEAL_PRIORITY_EN
  always_comb begin
    if (eligible[ACT_HEAL]) begin
      pick_valid = 1'b1;
      pick_code  = ACT_HEAL;
    end else begin
      pick_valid = rr_valid;
      pick_code  = rr_code;
    end
  end
`else
  assign pick_valid = rr_valid;
  assign pick_code  = rr_code;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      act_valid_q <= 1'b0;
      act_code_q  <= ACT_FEED;
      ptr_q       <= 2'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          act_valid_q <= 1'b0;
          if (pick_valid && !dead && !test_mode) begin
            act_code_q <= pick_code;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (dead) begin
            state_q <= IDLE;
          end else begin
            act_valid_q <= 1'b1;
            state_q     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (dead) begin
            act_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (act_ready) begin
            act_valid_q <= 1'b0;
            state_q     <= IDLE;
`ifdef PET_HEAL_PRIORITY_EN
            // An overriding HEAL grant leaves the rotation of the other three untouched.
            if (act_code_q != ACT_HEAL) begin
              ptr_q <= act_code_q + 2'd1;
            end
`else
            ptr_q <= act_code_q + 2'd1;
`endif
          end
        end
        default: begin
          act_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign act_valid = act_valid_q;
  assign act_code  = act_code_q;
  assign cooldown  = cd_flag;
  assign pending   = pending_q;
  assign sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_pet_action_arbiter.sv
// Self-checking bench for pet_action_arbiter: per-cycle vector table plus directed sequences
// for cooldown timing, held levels, stalled handshakes, dead, test_mode and heal priority.
module tb_pet_action_arbiter;
  import pet_pkg::*;

  localparam int unsigned ClkFreq   = 50;
  localparam int unsigned CooldownS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_v = 4'b0000;
  logic       dead_v = 1'b0;
  logic       tmode_v = 1'b0;
  logic       ready_v = 1'b0;
  logic       act_valid;
  logic [1:0] act_code;
  logic [3:0] cooldown;
  logic [3:0] pending;
  logic       sec_tick;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pet_action_arbiter #(
    .CLK_FREQ   (ClkFreq),
    .COOLDOWN_S (CooldownS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_feed  (req_v[0]),
    .req_sleep (req_v[1]),
    .req_play  (req_v[2]),
    .req_heal  (req_v[3]),
    .dead      (dead_v),
    .test_mode (tmode_v),
    .act_valid (act_valid),
    .act_code  (act_code),
    .act_ready (ready_v),
    .cooldown  (cooldown),
    .pending   (pending),
    .sec_tick  (sec_tick)
  );

  typedef struct {
    bit         rst_first;
    logic [3:0] req;
    logic       ready;
    logic       valid;
    logic [1:0] code;
    logic [3:0] pend;
    logic [3:0] cd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input logic [3:0] rq, input logic rdy, input logic v,
                     input logic [1:0] c, input logic [3:0] p, input logic [3:0] cd);
    vec_t e;
    e.rst_first = r; e.req = rq; e.ready = rdy; e.valid = v; e.code = c; e.pend = p; e.cd = cd;
    tbl.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_v = 4'b0000; dead_v = 1'b0; tmode_v = 1'b0; ready_v = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string name, output logic [1:0] code);
    int n = 0;
    while (!act_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!act_valid) begin
      errors++;
      $display("FAIL %s: act_valid got 0 expected 1 within 20 cycles", name);
    end
    code = act_code;
  endtask

  initial begin
    logic [1:0] c1, c2;
    int ticks, gap, grants, n;
    bit stable;

    // Single feed pulse, ready tied high: act_valid three cycles after the edge.
    add(1, 4'b0001, 1, 0, 2'd0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 1, 0, 2'd0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 1, 1, 2'd0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 4'b0001);
    add(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 4'b0001);
    // Simultaneous feed/play/heal edges, then a blocked feed edge and a fresh sleep edge.
    add(1, 4'b1101, 1, 0, 2'd0, 4'b1101, 4'b0000);
`ifdef PET_HEAL_PRIORITY_EN
    add(0, 4'b0000, 1, 0, 2'd3, 4'b1101, 4'b0000);
    add(0, 4'b0000, 1, 1, 2'd3, 4'b1101, 4'b0000);
    add(0, 4'b0000, 1, 0, 2'd3, 4'b0101, 4'b1000);
    add(0, 4'b0000, 1, 0, 2'd0, 4'b0101, 4'b1000);
    add(0, 4'b0000, 1, 1, 2'd0, 4'b0101, 4'b1000);
    add(0, 4'b0000, 1, 0, 2'd0, 4'b0100, 4'b1001);
    add(0, 4'b0000, 1, 0, 2'd2, 4'b0100, 4'b1001);
    add(0, 4'b0000, 1, 1, 2'd2, 4'b0100, 4'b1001);
    add(0, 4'b0000, 1, 0, 2'd2, 4'b0000, 4'b1101);
    add(0, 4'b0001, 1, 0, 2'd2, 4'b0000, 4'b1101);
    add(0, 4'b0011, 1, 0, 2'd2, 4'b0010, 4'b1101);
`else
    add(0, 4'b0000, 1, 0, 2'd0, 4'b1101, 4'b0000);
    add(0, 4'b0000, 1, 1, 2'd0, 4'b1101, 4'b0000);
    add(0, 4'b0000, 1, 0, 2'd0, 4'b1100, 4'b0001);
    add(0, 4'b0000, 1, 0, 2'd2, 4'b1100, 4'b0001);
    add(0, 4'b0000, 1, 1, 2'd2, 4'b1100, 4'b0001);
    add(0, 4'b0000, 1, 0, 2'd2, 4'b1000, 4'b0101);
    add(0, 4'b0000, 1, 0, 2'd3, 4'b1000, 4'b0101);
    add(0, 4'b0000, 1, 1, 2'd3, 4'b1000, 4'b0101);
    add(0, 4'b0000, 1, 0, 2'd3, 4'b0000, 4'b1101);
    add(0, 4'b0001, 1, 0, 2'd3, 4'b0000, 4'b1101);
    add(0, 4'b0011, 1, 0, 2'd3, 4'b0010, 4'b1101);
`endif
    add(0, 4'b0011, 1, 0, 2'd1, 4'b0010, 4'b1101);
    add(0, 4'b0000, 1, 1, 2'd1, 4'b0010, 4'b1101);
    add(0, 4'b0000, 1, 0, 2'd1, 4'b0000, 4'b1111);

    // Reset state while rst is held low.
    @(negedge clk);
    check("reset act_valid", act_valid, 0);
    check("reset act_code", act_code, 0);
    check("reset cooldown", cooldown, 0);
    check("reset pending", pending, 0);
    check("reset sec_tick", sec_tick, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_first) do_reset();
      req_v = tbl[i].req;
      ready_v = tbl[i].ready;
      step();
      check($sformatf("vec%0d act_valid", i), act_valid, tbl[i].valid);
      check($sformatf("vec%0d act_code", i), act_code, tbl[i].code);
      check($sformatf("vec%0d pending", i), pending, tbl[i].pend);
      check($sformatf("vec%0d cooldown", i), cooldown, tbl[i].cd);
    end

    // sec_tick: first pulse exactly CLK_FREQ cycles after reset, then every CLK_FREQ cycles.
    do_reset();
    repeat (ClkFreq - 1) step();
    check("tick before wrap", sec_tick, 0);
    step();
    check("first tick", sec_tick, 1);
    gap = 0;
    do begin
      step();
      gap++;
    end while (!sec_tick && gap < 2 * ClkFreq);
    check("tick period", gap, ClkFreq);

    // Cooldown spans exactly COOLDOWN_S ticks after the accept.
    do_reset();
    ready_v = 1'b1;
    req_v = 4'b0001;
    step();
    req_v = 4'b0000;
    wait_valid("cooldown grant", c1);
    step();
    check("cooldown loaded", cooldown, 4'b0001);
    ticks = 0;
    n = 0;
    while (cooldown[0] && n < 5 * ClkFreq) begin
      if (sec_tick) ticks++;
      step();
      n++;
    end
    check("cooldown cleared", cooldown[0], 0);
    check("cooldown ticks", ticks, CooldownS);

    // Held sleep: one grant only; a re-edge during cooldown is ignored.
    do_reset();
    ready_v = 1'b1;
    req_v = 4'b0010;
    grants = 0;
    repeat (8) begin
      step();
      if (act_valid) grants++;
    end
    req_v = 4'b0000;
    step();
    req_v = 4'b0010;
    step();
    check("sleep re-edge pending", pending, 4'b0000);
    check("sleep re-edge cooldown", cooldown, 4'b0010);
    repeat (10 * ClkFreq) begin
      step();
      if (act_valid) grants++;
    end
    check("sleep held grants", grants, 1);
    req_v = 4'b0000;

    // Stalled handshake: valid/code stable for 20 cycles, accept drops valid next cycle.
    do_reset();
    req_v = 4'b0100;
    step();
    req_v = 4'b0000;
    wait_valid("stall grant", c1);
    check("stall code", c1, ACT_PLAY);
    stable = 1'b1;
    repeat (20) begin
      step();
      if (!act_valid || act_code != ACT_PLAY) stable = 1'b0;
    end
    check("stall stable", stable, 1);
    ready_v = 1'b1;
    step();
    check("stall accept valid", act_valid, 0);
    check("stall accept pending", pending, 4'b0000);
    check("stall accept cooldown", cooldown, 4'b0100);
    ready_v = 1'b0;

    // dead during WAIT_ACK: drop valid, clear pending, no cooldown load, ignore edges.
    do_reset();
    req_v = 4'b1001;
    step();
    req_v = 4'b0000;
    wait_valid("dead grant", c1);
    check("dead grant code", c1, ACT_FEED);
    dead_v = 1'b1;
    step();
    check("dead valid", act_valid, 0);
    check("dead pending", pending, 4'b0000);
    check("dead cooldown", cooldown, 4'b0000);
    req_v = 4'b0010;
    step();
    req_v = 4'b0000;
    step();
    check("dead edge ignored", pending, 4'b0000);
    dead_v = 1'b0;
    repeat (5) step();
    check("after dead valid", act_valid, 0);

    // test_mode: requests latch but nothing issues until it clears.
    do_reset();
    tmode_v = 1'b1;
    req_v = 4'b0001;
    step();
    req_v = 4'b0000;
    step();
    check("test_mode pending", pending, 4'b0001);
    repeat (5) step();
    check("test_mode hold", act_valid, 0);
    tmode_v = 1'b0;
    step();
    step();
    check("test_mode release valid", act_valid, 1);
    check("test_mode release code", act_code, ACT_FEED);

    // Feed and heal together with pointer at 0.
    do_reset();
    ready_v = 1'b1;
    req_v = 4'b1001;
    step();
    req_v = 4'b0000;
    wait_valid("prio first", c1);
    step();
    wait_valid("prio second", c2);
`ifdef PET_HEAL_PRIORITY_EN
    check("prio first code", c1, ACT_HEAL);
    check("prio second code", c2, ACT_FEED);
`else
    check("prio first code", c1, ACT_FEED);
    check("prio second code", c2, ACT_HEAL);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pet_action_arbiter.md
Name: pet_action_arbiter

Overview:
- Sits between the user-input layer (debounced buttons, light sensor, ultrasonic echo) and the pet stats core.
- Captures action requests (feed, sleep, play, heal) and arbitrates them round-robin.
- Issues one action at a time to the stats core over a valid/ready handshake.
- Enforces a per-action cooldown measured in seconds, so one held or repeated input cannot saturate a stat.

Parameters:
- CLK_FREQ, default 50: clock cycles per second (50_000_000 on board; 50 for simulation).
- COOLDOWN_S, default 3: seconds an action stays blocked after it is accepted. Range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_feed  in  1  feed request, level
- req_sleep  in  1  light-out request, level
- req_play  in  1  echo/play request, level
- req_heal  in  1  heal request, level
- dead  in  1  pet dead (health == 0); blocks all actions
- test_mode  in  1  stats core in test mode; arbiter holds off issuing
- act_valid  out  1  action offered to stats core
- act_code  out  2  0=FEED, 1=SLEEP, 2=PLAY, 3=HEAL
- act_ready  in  1  stats core accepts action
- cooldown  out  4  per-action blocked flags, bit index = act_code
- pending  out  4  per-action latched request flags
- sec_tick  out  1  one-cycle pulse, once per second

Behaviour:
- Reset (rst low, asynchronous) clears everything: act_valid=0, act_code=0, cooldown=0, pending=0, sec_tick=0, round-robin pointer=0, all counters=0, FSM=IDLE.
- Input capture:
  - Each req_* is registered once; a rising edge (prev=0, now=1) sets its pending bit.
  - A held level does not re-trigger.
  - A rising edge is ignored while that action's pending bit or cooldown bit is already set.
- Tick generator:
  - Counter 0..CLK_FREQ-1; sec_tick=1 on the cycle the counter wraps to 0.
  - Free-running; unaffected by dead and test_mode.
- Cooldown:
  - 4-bit counter per action, loaded with COOLDOWN_S when that action's handshake completes.
  - Decrements on sec_tick; cooldown[i] = (cnt_i != 0).
  - A load in the same cycle as sec_tick takes the load.
- FSM states: IDLE, ISSUE, WAIT_ACK.
  - IDLE: eligible = pending & ~cooldown. If eligible != 0 and dead=0 and test_mode=0, pick the first eligible bit at or after the pointer (wrap 3->0). Register act_code, go to ISSUE.
  - ISSUE: act_valid=1 registered (one cycle after the IDLE decision), go to WAIT_ACK.
  - WAIT_ACK: hold act_valid and act_code stable until act_ready=1. On accept: clear the pending bit, load the cooldown, set pointer = act_code+1 mod 4, drop act_valid next cycle, return to IDLE.
  - act_ready sampled while act_valid=0 is ignored.
- Latency: rising edge on req_* to act_valid high is 3 cycles when the arbiter is idle and eligible (register, pending, ISSUE).
- dead=1:
  - All pending bits are cleared every cycle; new edges are ignored.
  - In WAIT_ACK, act_valid drops on the next cycle and the FSM returns to IDLE with no cooldown load.
  - Cooldown counters keep decrementing.
- test_mode=1: pending still latches. The FSM does not leave IDLE; an in-flight WAIT_ACK completes normally.
- Simultaneous edges on several inputs: all are latched and served in round-robin order, one handshake each.
- Pending request while its cooldown is active: stays pending and is issued once cooldown clears.

Optional Feature:
- Macro: PET_HEAL_PRIORITY_EN.
- Defined: HEAL (bit 3) wins whenever it is eligible, regardless of the pointer. The other three actions stay round-robin. Granting HEAL does not move the pointer.
- Undefined: pure 4-way round-robin as above.

Decomposition:
- Shared package pet_pkg:
  - action codes ACT_FEED=2'd0, ACT_SLEEP=2'd1, ACT_PLAY=2'd2, ACT_HEAL=2'd3
  - NUM_ACT=4
  - FSM state encodings IDLE/ISSUE/WAIT_ACK
  - stats core reuses the action codes
- One sub-module: rr_pick4. Combinational round-robin picker: inputs eligible[3:0] and pointer[1:0]; outputs grant_valid and grant_code[1:0]. Priority override is applied in the parent under the macro.

Test Plan:
- Reset, then one pulse on req_feed with act_ready tied 1 -> act_valid high 3 cycles later with act_code=0; cooldown[0]=1 for 3 sec_ticks, then 0.
- Rising edges on feed, play and heal in the same cycle, act_ready=1 -> grants in order 0, 2, 3; pending=0 afterwards; pointer ends at 0.
- req_sleep held high for 10 s -> exactly one grant (no re-trigger on level); second edge during cooldown ignored.
- act_ready held 0 for 20 cycles -> act_valid and act_code stable the whole time; asserting act_ready completes the handshake; act_valid low on the next cycle.
- dead asserted in WAIT_ACK -> act_valid low next cycle, pending=0, no cooldown load; edges ignored while dead=1.
- With PET_HEAL_PRIORITY_EN, pointer=0, eligible=4'b1001 -> HEAL granted first, then FEED. Without the macro -> FEED first.
